// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  // Width of the per-bit cycle counter, i.e. $clog2(CLKS_PER_BIT), never below 1.
  function automatic int cnt_width(input int clks_per_bit);
    return (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; the head word is visible on dout without popping.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A pop frees the slot a same-cycle push needs, so a full FIFO still accepts.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign dout  = empty ? '0 : mem[rd_ptr];

  // Storage array; contents need no reset because dout is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two; count tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_irq.sv
// 8N1 UART receiver feeding a show-ahead FIFO, with a one-cycle interrupt per stored byte.
module uart_rx_irq
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            rx,
  input  logic                            rd_en,
  input  logic                            clr_err,
  output logic [UART_DATA_W-1:0]          rd_data,
  output logic                            rx_valid,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] rx_count,
  output logic                            intrrupt,
  output logic                            frame_err,
  output logic                            overrun
);

  localparam int CNT_W = cnt_width(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(UART_DATA_W);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_BIT  = IDX_W'(UART_DATA_W - 1);

  logic                   sync1, rxs;
  rx_state_t              state, state_next;
  logic [CNT_W-1:0]       cnt, cnt_next;
  logic [IDX_W-1:0]       bit_idx, bit_idx_next;
  logic [UART_DATA_W-1:0] shift_reg, shift_next;
  logic                   stop_sample;
  logic                   stop_ok, frame_set, overrun_set;
  logic                   pop_ok, push_ok;
  logic                   fifo_full, fifo_empty;

  // Two-flop synchronizer; resets to the idle line level so no false start is seen.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= rx;
      rxs   <= sync1;
    end
  end

  // Receive FSM state and bit-timing registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      bit_idx   <= bit_idx_next;
      shift_reg <= shift_next;
    end
  end

  // Next-state logic: mid-bit sampling timed from the centre of the start bit.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    bit_idx_next = bit_idx;
    shift_next   = shift_reg;
    stop_sample  = 1'b0;
    case (state)
      IDLE: begin
        if (!rxs) begin
          state_next = START;
          cnt_next   = '0;
        end
      end
      START: begin
        if (cnt == HALF_LAST) begin
          if (rxs) begin
            state_next = IDLE;
          end else begin
            state_next   = DATA;
            cnt_next     = '0;
            bit_idx_next = '0;
          end
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == FULL_LAST) begin
          cnt_next            = '0;
          shift_next[bit_idx] = rxs;
          if (bit_idx == LAST_BIT) begin
            state_next = STOP;
          end else begin
            bit_idx_next = bit_idx + 1'b1;
          end
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == FULL_LAST) begin
          state_next  = IDLE;
          cnt_next    = '0;
          stop_sample = 1'b1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign stop_ok     = stop_sample && rxs;
  assign frame_set   = stop_sample && !rxs;
  assign pop_ok      = rd_en && !fifo_empty;
  assign push_ok     = stop_ok && (!fifo_full || pop_ok);
  assign overrun_set = stop_ok && fifo_full && !pop_ok;
  assign rx_valid    = !fifo_empty;

  sync_fifo #(
    .WIDTH (UART_DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (push_ok),
    .pop   (pop_ok),
    .din   (shift_reg),
    .dout  (rd_data),
    .count (rx_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Interrupt pulse follows each accepted push; sticky flags where set beats clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      intrrupt  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      intrrupt <= push_ok;
      if (frame_set)    frame_err <= 1'b1;
      else if (clr_err) frame_err <= 1'b0;
      if (overrun_set)  overrun <= 1'b1;
      else if (clr_err) overrun <= 1'b0;
    end
  end

endmodule

// File: doc/uart_rx_irq.md
Name: uart_rx_irq

Overview:
- Serial UART receiver for the three-stage pipeline's peripheral side: 8N1 frames, LSB first.
- Received bytes are buffered in a small show-ahead FIFO.
- For every byte accepted into the FIFO, the block issues a one-cycle `intrrupt` pulse to the core.
- It is the source end of the core's `intrrupt` input; the core drains bytes with `rd_en`.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit (power of two not required, minimum 4).
- FIFO_DEPTH, 4, receive buffer entries (power of two, minimum 2).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- rx  input  1  serial line, idle high, asynchronous to clk.
- rd_en  input  1  pop the FIFO head this cycle.
- clr_err  input  1  clear sticky error flags.
- rd_data  output  8  FIFO head byte (show-ahead); 8'h00 when empty.
- rx_valid  output  1  FIFO not empty.
- rx_count  output  $clog2(FIFO_DEPTH+1)  FIFO occupancy.
- intrrupt  output  1  one-cycle pulse per accepted byte.
- frame_err  output  1  sticky: a stop bit was sampled low.
- overrun  output  1  sticky: a byte was dropped because the FIFO was full.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs 0; rd_data = 8'h00.
  - Synchronizer flops reset to 1. FSM goes to IDLE; bit counter and cycle counter go to 0; FIFO is emptied.
- rx passes through a 2-flop synchronizer; `rxs` denotes its output. All sampling uses rxs.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: on rxs==0, go to START and clear the cycle counter.
  - START: count to CLKS_PER_BIT/2-1 (mid start bit), then sample rxs.
    - rxs==1 → glitch: return to IDLE with no side effects.
    - rxs==0 → clear the cycle counter and go to DATA.
  - DATA: sample rxs every CLKS_PER_BIT cycles (mid-bit) into shift register bit[bit_idx], LSB first. After bit 7, go to STOP.
  - STOP: sample rxs after CLKS_PER_BIT cycles.
    - rxs==1 and FIFO not full → push byte. intrrupt=1 in the cycle after the push edge, exactly one cycle.
    - rxs==1 and FIFO full → drop byte, set overrun, no intrrupt.
    - rxs==0 → drop byte, set frame_err, no intrrupt.
    - In all three cases, go to IDLE on the same edge. IDLE re-arms immediately; if rxs is still 0 after a frame error, a new START begins.
- Latency:
  - Push occurs at the sample edge of the stop bit, about 9.5 bit times after the start edge, plus 2 synchronizer cycles.
  - intrrupt and rx_valid rise together, 1 cycle after that push edge.
- FIFO rules:
  - rd_en with FIFO empty is ignored.
  - Simultaneous push and pop:
    - when the FIFO is full, the push is accepted, count is unchanged and overrun is not set;
    - when the FIFO is empty, the pushed byte is stored and the pop is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- Error flags: clr_err clears both flags on the next edge. If a set event and clr_err occur in the same cycle, set wins.
- rd_en and clr_err have no effect on the receive FSM.

Decomposition:
- Package uart_pkg:
  - rx_state_t enum {IDLE, START, DATA, STOP};
  - UART_DATA_W=8 constant;
  - localparam helper for the counter width: $clog2(CLKS_PER_BIT).
- Sub-module sync_fifo, parameterized WIDTH/DEPTH, with ports push, pop, din, dout, count, full, empty. It is show-ahead and resets asynchronously active-low. uart_rx_irq instantiates it once.

Test Plan:
- Single byte 8'hA5 sent at CLKS_PER_BIT=16 → exactly one intrrupt pulse; then rx_valid=1, rd_data=8'hA5, rx_count=1. After one rd_en: rx_valid=0, rd_data=8'h00.
- Five back-to-back bytes 8'h01..8'h05 with no reads, FIFO_DEPTH=4 → 4 intrrupt pulses and overrun=1. Draining yields 01,02,03,04. clr_err then gives overrun=0.
- Stop bit driven 0 on byte 8'h3C → frame_err=1, no intrrupt, rx_count stays 0. The next valid frame 8'h55 is received normally.
- Start glitch: rx low for 4 cycles, then high → FSM returns to IDLE, no push, no flags, no intrrupt.
- reset=0 asserted mid-DATA of byte 8'hFF → all outputs 0 immediately. After release, the next full frame 8'h81 is received correctly with a single intrrupt.
- FIFO full and rd_en asserted in the same cycle as the stop-bit sample of byte 8'h77 → rx_count remains 4, overrun=0, and the last entry read out is 8'h77.
